display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Sequences time-multiplexing of N common-anode 7-segment digits for the Gray/BCD display path.
//  Inserts a blanking guard between digits to prevent ghosting.
//  Accepts new BCD frames over a valid/ready handshake and commits them atomically at frame boundaries.
//  Sits between the binary-to-BCD stage and the BCD-to-7-segment decoder.
// PARAMETERS
//  N_DIGITS     2      number of multiplexed digits (>=2)
//  DIGIT_TICKS  27000  clk cycles each digit is lit (>=1)
//  BLANK_TICKS  270    clk cycles with all anodes off before each digit (>=1)
//  CNT_W        $clog2(max(DIGIT_TICKS,BLANK_TICKS)+1)  derived localparam, not overridable
// PORTS
//  clk_i     in   1            system clock; all logic on rising edge
//  rst_i     in   1            reset, asynchronous, active-high
//  load_i    in   1            new frame valid
//  bcd_i     in   4*N_DIGITS   frame; nibble k = digit k (k=0 is units)
//  ready_o   out  1            block can accept a frame
//  anodo_o   out  N_DIGITS     digit enables, active-low
//  digito_o  out  4            BCD nibble of the currently selected digit
//  blank_o   out  1            1 during blank phase
//  frame_o   out  1            one-cycle pulse at end of the last digit's lit phase
// BEHAVIOUR
//  Reset (async assert, sync release): state=BLANK, idx=0, tick=0, active=0, pending empty.
//   Outputs: anodo_o=all 1, digito_o=0, blank_o=1, frame_o=0, ready_o=1.
//  All outputs are registered; no combinational path from inputs to outputs.
//  FSM:
//   BLANK: anodo_o all 1, blank_o=1, held BLANK_TICKS cycles -> SHOW.
//   SHOW: anodo_o[idx]=0, others 1, blank_o=0, held DIGIT_TICKS cycles -> BLANK.
//   On SHOW exit, idx=(idx+1) mod N_DIGITS.
//   On SHOW exit with idx==N_DIGITS-1, frame_o=1 for exactly that one cycle.
//   Frame period = N_DIGITS*(DIGIT_TICKS+BLANK_TICKS) cycles.
//  digito_o: loaded with active[idx] on the first cycle of BLANK, stable through the following SHOW.
//  Handshake:
//   Frame accepted when load_i && ready_o at a rising edge: bcd_i -> pending, ready_o=0 next cycle.
//   load_i while ready_o=0 is ignored; bcd_i is don't-care when load_i=0.
//   Commit: on the BLANK entry cycle with new idx==0, if pending is full, pending -> active;
//    ready_o=1 on the following cycle.
//   A digit never mixes old and new frame data.
//  Boundary cases:
//   - Load arriving on the commit cycle: cannot be accepted (ready_o=0).
//   - Load on the very cycle of a frame boundary: held until the next frame boundary.
//   - Reset mid-SHOW: anodes off immediately (async); pending frame discarded; active=0.
//   - Counter wrap: tick counts 0..TICKS-1; no overflow for any legal parameter.
//  Non-BCD nibbles (>9) are passed through unchanged; blanking of those is the decoder's job.
// STRUCTURE
//  Shared package disp_pkg:
//   - state enum {BLANK, SHOW}
//   - ANODE_OFF constant (all ones)
//   - BCD nibble width localparam (4)
//  Sub-module scan_timer: load/terminal-count down-counter.
//   Reloaded with BLANK_TICKS-1 or DIGIT_TICKS-1 on phase change; asserts done_o at 0.
//  Top holds: FSM, idx counter, active/pending registers, output registers.
// TESTING (bench params N_DIGITS=2, DIGIT_TICKS=4, BLANK_TICKS=2)
//  1. Reset release, no load:
//     anodo_o = 11,11 | 10 x4 | 11 x2 | 01 x4; frame_o on cycle 12, period 12; digito_o=0 throughout.
//  2. load_i=1, bcd_i=8'h37 in first BLANK:
//     ready_o=0 next cycle; from next frame, digito_o=7 with anodo_o=10, =3 with anodo_o=01;
//     ready_o=1 the cycle after commit.
//  3. Second load (8'h55) while ready_o=0:
//     ignored; display keeps 8'h37; a load after ready_o returns to 1 is accepted.
//  4. Load of 8'h91 one cycle before frame boundary:
//     committed at that boundary; no digit shows a mixed frame.
//  5. rst_i asserted mid-SHOW between edges:
//     anodo_o=11 before next edge; after release, display shows 00 and ready_o=1;
//     pending 8'h42 loaded pre-reset never appears.
//  6. Params N_DIGITS=4, DIGIT_TICKS=1, BLANK_TICKS=1:
//     anodo_o cycles 1110,1101,1011,0111 each separated by 1111; frame period 8.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment digit scan controller.
package disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Per-anode "off" level; anodes are active-low.
    localparam logic ANODE_OFF = 1'b1;

    localparam int unsigned BCD_W = 4;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Frame-load handshake and scan outputs of display_scan_ctrl.
interface display_scan_ctrl_if
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS = 2
);
    logic                      load_i;
    logic [N_DIGITS*BCD_W-1:0] bcd_i;
    logic                      ready_o;
    logic [N_DIGITS-1:0]       anodo_o;
    logic [BCD_W-1:0]          digito_o;
    logic                      blank_o;
    logic                      frame_o;

    modport master (
        output load_i, bcd_i,
        input  ready_o, anodo_o, digito_o, blank_o, frame_o
    );

    modport slave (
        input  load_i, bcd_i,
        output ready_o, anodo_o, digito_o, blank_o, frame_o
    );
endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter; done_o flags a count of zero (registered alongside the count).
module scan_timer #(
    parameter int unsigned CNT_W   = 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_o;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_o != '0) begin
            cnt_d = cnt_o - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o  <= CNT_W'(RST_VAL);
            done_o <= (RST_VAL == 0);
        end else begin
            cnt_o  <= cnt_d;
            done_o <= (cnt_d == '0);
        end
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexes N common-anode digits with a blanking guard before each digit;
// new frames are taken over valid/ready and committed only at frame boundaries.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 2,
    parameter int unsigned DIGIT_TICKS = 27000,
    parameter int unsigned BLANK_TICKS = 270
) (
    input  logic               clk_i,
    input  logic               rst_i,
    display_scan_ctrl_if.slave bus
);
    localparam int unsigned MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int unsigned IDX_W     = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    state_t                             state_q, state_nxt;
    logic [IDX_W-1:0]                   idx_q, idx_nxt;
    logic [N_DIGITS-1:0][BCD_W-1:0]     active_q, pending_q;
    logic                               pend_full_q, commit_q, commit;
    logic                               ready_q, blank_q, blank_d, frame_q, frame_d;
    logic [N_DIGITS-1:0]                anodo_q, anodo_d;
    logic [BCD_W-1:0]                   digito_q, digito_d;
    logic                               t_load, t_done;
    logic [CNT_W-1:0]                   t_val, t_cnt;

    scan_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (BLANK_TICKS - 1)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (t_load),
        .load_val_i (t_val),
        .cnt_o      (t_cnt),
        .done_o     (t_done)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        t_load    = 1'b0;
        t_val     = CNT_W'(BLANK_TICKS - 1);
        commit    = 1'b0;
        anodo_d   = {N_DIGITS{ANODE_OFF}};
        blank_d   = 1'b1;
        frame_d   = 1'b0;
        digito_d  = digito_q;
        unique case (state_q)
            BLANK: begin
                if (t_done) begin
                    state_nxt = SHOW;
                    t_load    = 1'b1;
                    t_val     = CNT_W'(DIGIT_TICKS - 1);
                end
            end
            SHOW: begin
                if (t_done) begin
                    state_nxt = BLANK;
                    t_load    = 1'b1;
                    idx_nxt   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    commit    = (idx_q == LAST_IDX) && pend_full_q;
                    digito_d  = commit ? pending_q[idx_nxt] : active_q[idx_nxt];
                end
            end
            default: ;
        endcase
        if (state_nxt == SHOW) begin
            anodo_d[idx_nxt] = 1'b0;
            blank_d          = 1'b0;
            // Flag the final lit cycle of the last digit.
            frame_d = (idx_nxt == LAST_IDX) &&
                      ((state_q == BLANK) ? (DIGIT_TICKS == 1) : (t_cnt == CNT_W'(1)));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= BLANK;
            idx_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            commit_q    <= 1'b0;
            ready_q     <= 1'b1;
            anodo_q     <= {N_DIGITS{ANODE_OFF}};
            digito_q    <= '0;
            blank_q     <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            idx_q    <= idx_nxt;
            commit_q <= commit;
            anodo_q  <= anodo_d;
            digito_q <= digito_d;
            blank_q  <= blank_d;
            frame_q  <= frame_d;
            // ready stays low through the commit cycle, returns the cycle after.
            if (commit) begin
                active_q    <= pending_q;
                pend_full_q <= 1'b0;
            end else if (bus.load_i && ready_q) begin
                pending_q   <= bus.bcd_i;
                pend_full_q <= 1'b1;
                ready_q     <= 1'b0;
            end
            if (commit_q) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.anodo_o  = anodo_q;
    assign bus.digito_o = digito_q;
    assign bus.blank_o  = blank_q;
    assign bus.frame_o  = frame_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: two configurations, frame-level reference model.
module tb_display_scan_ctrl;
    localparam int NA = 2, DA = 4, BA = 2, PA = NA * (DA + BA);
    localparam int NB = 4, DB = 1, BB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan_ctrl_if #(.N_DIGITS(NA)) bus_a ();
    display_scan_ctrl_if #(.N_DIGITS(NB)) bus_b ();

    display_scan_ctrl #(.N_DIGITS(NA), .DIGIT_TICKS(DA), .BLANK_TICKS(BA)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (bus_a.slave));
    display_scan_ctrl #(.N_DIGITS(NB), .DIGIT_TICKS(DB), .BLANK_TICKS(BB)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (bus_b.slave));

    typedef struct {
        int         c;
        logic [3:0] anodo;
        logic [3:0] digito;
        logic       blank;
        logic       frame;
        logic       ready;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   total = 0;
    int   bad   = 0;

    // Reference model state, one slot per configuration.
    int          cyc[2];
    bit          pend[2];
    int          acc_c[2];
    int          commit_c[2];
    logic [15:0] pend_data[2];
    logic [15:0] disp[2];

    function automatic int nd(input int u); return (u == 0) ? NA : NB; endfunction
    function automatic int dt(input int u); return (u == 0) ? DA : DB; endfunction
    function automatic int bt(input int u); return (u == 0) ? BA : BB; endfunction

    function automatic bit lit_at(input int u, input int c);
        int s;
        s = dt(u) + bt(u);
        return ((c % (nd(u) * s)) % s) >= bt(u);
    endfunction

    task automatic chk(input string nm, input int c, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, c, act, exp);
        end
    endtask

    // Frame k shows the frame accepted at least two cycles before its start; each
    // slot is BLANK_TICKS dark then DIGIT_TICKS lit.
    task automatic model_cycle(input int u, input bit ld, input logic [15:0] bcd, output exp_t e);
        int s, per, p, d, ph;
        s   = dt(u) + bt(u);
        per = nd(u) * s;
        p   = cyc[u] % per;
        d   = p / s;
        ph  = p % s;
        if (cyc[u] != 0 && p == 0 && pend[u] && acc_c[u] + 2 <= cyc[u]) begin
            disp[u]     = pend_data[u];
            pend[u]     = 1'b0;
            commit_c[u] = cyc[u];
        end
        e.c     = cyc[u];
        e.anodo = 4'hF;
        if (ph >= bt(u)) e.anodo[d] = 1'b0;
        e.blank  = (ph < bt(u));
        e.frame  = (p == per - 1);
        e.digito = disp[u][d*4 +: 4];
        e.ready  = !pend[u] && (commit_c[u] != cyc[u]);
        if (ld && e.ready) begin
            pend[u]      = 1'b1;
            acc_c[u]     = cyc[u];
            pend_data[u] = (u == 0) ? {8'h00, bcd[7:0]} : bcd;
        end
        cyc[u]++;
    endtask

    task automatic cyc_body(input bit ld, input logic [15:0] bcd);
        exp_t e;
        model_cycle(0, ld, bcd, e);
        qa.push_back(e);
        model_cycle(1, ld, bcd, e);
        qb.push_back(e);
        bus_a.load_i = ld;
        bus_a.bcd_i  = bcd[7:0];
        bus_b.load_i = ld;
        bus_b.bcd_i  = bcd;
    endtask

    task automatic cyc_step(input bit ld, input logic [15:0] bcd);
        @(posedge clk);
        #1;
        cyc_body(ld, bcd);
    endtask

    task automatic do_reset(input bit mid_show);
        @(posedge clk);
        #2;
        bus_a.load_i = 1'b0;
        bus_b.load_i = 1'b0;
        if (mid_show) chk("pre_rst_lit_a", cyc[0], int'(bus_a.blank_o), 0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_anodo_a", cyc[0], int'(bus_a.anodo_o), 32'h3);
        chk("async_anodo_b", cyc[1], int'(bus_b.anodo_o), 32'hF);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digito_a", 0, int'(bus_a.digito_o), 0);
        chk("rst_blank_a", 0, int'(bus_a.blank_o), 1);
        chk("rst_frame_a", 0, int'(bus_a.frame_o), 0);
        chk("rst_ready_a", 0, int'(bus_a.ready_o), 1);
        chk("rst_ready_b", 0, int'(bus_b.ready_o), 1);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            cyc[u]       = 0;
            pend[u]      = 1'b0;
            acc_c[u]     = 0;
            commit_c[u]  = -1;
            pend_data[u] = '0;
            disp[u]      = '0;
        end
        cyc_body(1'b0, 16'h0);
    endtask

    // Monitor: one expected record per DUT cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_anodo",  ea.c, int'({2'b11, bus_a.anodo_o}), int'(ea.anodo));
            chk("a_digito", ea.c, int'(bus_a.digito_o), int'(ea.digito));
            chk("a_blank",  ea.c, int'(bus_a.blank_o),  int'(ea.blank));
            chk("a_frame",  ea.c, int'(bus_a.frame_o),  int'(ea.frame));
            chk("a_ready",  ea.c, int'(bus_a.ready_o),  int'(ea.ready));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_anodo",  eb.c, int'(bus_b.anodo_o),  int'(eb.anodo));
            chk("b_digito", eb.c, int'(bus_b.digito_o), int'(eb.digito));
            chk("b_blank",  eb.c, int'(bus_b.blank_o),  int'(eb.blank));
            chk("b_frame",  eb.c, int'(bus_b.frame_o),  int'(eb.frame));
            chk("b_ready",  eb.c, int'(bus_b.ready_o),  int'(eb.ready));
        end
    end

    initial begin
        bus_a.load_i = 1'b0;
        bus_a.bcd_i  = '0;
        bus_b.load_i = 1'b0;
        bus_b.bcd_i  = '0;
        do_reset(1'b0);

        // Free-running scan with no frame loaded.
        repeat (23) cyc_step(1'b0, 16'h0);

        // Load in a blanking phase, then an overlapping load that must be ignored.
        cyc_step(1'b1, 16'h0037);
        cyc_step(1'b1, 16'h0055);
        repeat (30) cyc_step(1'b0, 16'h0);
        for (int i = 0; i < 50 && pend[0]; i++) cyc_step(1'b0, 16'h0);
        chk("wait_ready", cyc[0], int'(pend[0]), 0);
        cyc_step(1'b1, 16'h0019);

        // Load one cycle before a frame boundary.
        for (int i = 0; i < 100 && !(!pend[0] && cyc[0] % PA == PA - 2); i++) cyc_step(1'b0, 16'h0);
        chk("wait_pre_boundary", cyc[0], int'(!pend[0] && cyc[0] % PA == PA - 2), 1);
        cyc_step(1'b1, 16'h0091);
        repeat (30) cyc_step(1'b0, 16'h0);

        // Load on the frame-boundary cycle itself.
        for (int i = 0; i < 100 && !(!pend[0] && cyc[0] % PA == PA - 1); i++) cyc_step(1'b0, 16'h0);
        chk("wait_boundary", cyc[0], int'(!pend[0] && cyc[0] % PA == PA - 1), 1);
        cyc_step(1'b1, 16'h00A5);
        repeat (40) cyc_step(1'b0, 16'h0);

        repeat (800) cyc_step($urandom_range(0, 5) == 0, 16'($urandom));

        // Reset while a digit is lit with a frame still pending.
        for (int i = 0; i < 100 && !(!pend[0] && lit_at(0, cyc[0]) && lit_at(0, cyc[0] + 1)); i++)
            cyc_step(1'b0, 16'h0);
        chk("wait_lit", cyc[0], int'(!pend[0] && lit_at(0, cyc[0]) && lit_at(0, cyc[0] + 1)), 1);
        cyc_step(1'b1, 16'h0042);
        do_reset(1'b1);
        repeat (60) cyc_step(1'b0, 16'($urandom));

        repeat (300) cyc_step($urandom_range(0, 4) == 0, 16'($urandom));

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
